mul_ex_unit: RTL

- Multiplier execution unit that consumes entries issued from the mul reservation station.
- Accepts one op (signedness flags, high/low select, two 32-bit operands, RRF tag) and computes the 64-bit product iteratively.
- Broadcasts a one-cycle exfin_mul result (tag + 32-bit result) to the RS entries' forwarding units and the RRF/ROB.
- Covers RV32M MUL, MULH, MULHSU and MULHU.

---
 rtl/mul_ex_unit_pkg.sv | 22 ++
 rtl/mul_iter_step.sv | 26 ++
 rtl/mul_ex_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mul_ex_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_ex_unit_pkg : shared widths and FSM encodings for the mul execution unit
// Rev 1.0
// ---------------------------------------------------------------------------
package mul_ex_unit_pkg;

  localparam int RV32_DATA_WIDTH = 32;
  localparam int RRF_ENT_SEL     = 6;

  localparam logic [1:0] MUL_STATE_IDLE = 2'd0;
  localparam logic [1:0] MUL_STATE_CALC = 2'd1;
  localparam logic [1:0] MUL_STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MUL_STATE_IDLE,
    ST_CALC = MUL_STATE_CALC,
    ST_DONE = MUL_STATE_DONE
  } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/mul_iter_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_iter_step : one radix-2^STEP partial-product accumulate (combinational)
// Rev 1.0
// ---------------------------------------------------------------------------
module mul_iter_step #(
  parameter int DATA_W = 32,
  parameter int STEP   = 4,
  parameter int SH_W   = 5
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   mag,
  input  logic [STEP-1:0]     mbits,
  input  logic [SH_W-1:0]     shift,
  output logic [2*DATA_W-1:0] acc_next
);

  logic [DATA_W+STEP-1:0] partial;

  always_comb begin
    partial  = {{STEP{1'b0}}, mag} * {{DATA_W{1'b0}}, mbits};
    acc_next = acc + ({{(DATA_W-STEP){1'b0}}, partial} << shift);
  end

endmodule
`default_nettype wire

// File: rtl/mul_ex_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_ex_unit : iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) with
// one-cycle exfin broadcast. Optional macro MUL_ZERO_BYPASS_EN. Rev 1.0
// ---------------------------------------------------------------------------
module mul_ex_unit
  import mul_ex_unit_pkg::*;
#(
  parameter int DATA_W = RV32_DATA_WIDTH,
  parameter int TAG_W  = RRF_ENT_SEL,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue_vld,
  output logic              o_ready,
  input  logic              i_mul_signed1,
  input  logic              i_mul_signed2,
  input  logic              i_mul_sel_high,
  input  logic [DATA_W-1:0] i_rs1_srcopr,
  input  logic [DATA_W-1:0] i_rs2_srcopr,
  input  logic [TAG_W-1:0]  i_rrftag,
  input  logic              i_kill,
  output logic              o_exfin_mul,
  output logic [TAG_W-1:0]  o_ex_mul_rrftag,
  output logic [DATA_W-1:0] o_exfin_mul_res
);

  localparam int NSTEPS = DATA_W / STEP;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int SH_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NSTEPS - 1);

  mul_state_e          state;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mplier;
  logic                neg;
  logic                sel_high;
  logic [TAG_W-1:0]    tag;
  logic [CNT_W-1:0]    counter;

  logic                accept;
  logic                rs1_neg;
  logic                rs2_neg;
  logic                zero_op;
  logic [DATA_W-1:0]   rs1_mag;
  logic [DATA_W-1:0]   rs2_mag;
  logic [SH_W-1:0]     shift;
  logic [2*DATA_W-1:0] acc_next;
  logic [2*DATA_W-1:0] prod;

  assign o_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign accept  = i_issue_vld && o_ready && !i_kill;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (i_rs1_srcopr == '0) || (i_rs2_srcopr == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Sign is handled once up front: multiply magnitudes, negate the final product.
  always_comb begin
    rs1_neg = i_mul_signed1 & i_rs1_srcopr[DATA_W-1];
    rs2_neg = i_mul_signed2 & i_rs2_srcopr[DATA_W-1];
    rs1_mag = rs1_neg ? -i_rs1_srcopr : i_rs1_srcopr;
    rs2_mag = rs2_neg ? -i_rs2_srcopr : i_rs2_srcopr;
    shift   = SH_W'(STEP * (NSTEPS - 1 - int'(counter)));
    prod    = neg ? -acc_next : acc_next;
  end

  mul_iter_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP),
    .SH_W   (SH_W)
  ) u_step (
    .acc      (acc),
    .mag      (mag1),
    .mbits    (mplier[STEP-1:0]),
    .shift    (shift),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      acc             <= '0;
      mag1            <= '0;
      mplier          <= '0;
      neg             <= 1'b0;
      sel_high        <= 1'b0;
      tag             <= '0;
      counter         <= '0;
      o_exfin_mul     <= 1'b0;
      o_ex_mul_rrftag <= '0;
      o_exfin_mul_res <= '0;
    end else begin
      o_exfin_mul <= 1'b0;
      if (accept) begin
        tag      <= i_rrftag;
        sel_high <= i_mul_sel_high;
        neg      <= rs1_neg ^ rs2_neg;
        mag1     <= rs1_mag;
        mplier   <= rs2_mag;
        acc      <= '0;
        counter  <= CNT_INIT;
        if (zero_op) begin
          state           <= ST_DONE;
          o_exfin_mul     <= 1'b1;
          o_ex_mul_rrftag <= i_rrftag;
          o_exfin_mul_res <= '0;
        end else begin
          state <= ST_CALC;
        end
      end else begin
        case (state)
          ST_CALC: begin
            if (i_kill) begin
              state <= ST_IDLE;
            end else begin
              acc    <= acc_next;
              mplier <= mplier >> STEP;
              if (counter == '0) begin
                state           <= ST_DONE;
                o_exfin_mul     <= 1'b1;
                o_ex_mul_rrftag <= tag;
                o_exfin_mul_res <= sel_high ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
              end else begin
                counter <= counter - 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
